// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: bundles the requester handshakes, the FIFO write port and the
// monitoring/status signals of fifo_wr_arbiter.
//   master : arbiter view (drives req_ready, fifo_wr_en, fifo_data_in, grant_id,
//            wr_count, err_overflow)
//   slave  : environment view (drives req_valid, req_data, FIFO flags, clr_err)
interface fifo_wr_arbiter_if #(
    parameter int N = 4,
    parameter int W = 16
);
    localparam int IW = $clog2(N);
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_data_in;
    logic           fifo_full;
    logic           fifo_almostfull;
    logic           fifo_wr_ack;
    logic           fifo_overflow;
    logic [IW-1:0]  grant_id;
    logic [15:0]    wr_count;
    logic           err_overflow;
    logic           clr_err;
    modport master (
        input  req_valid, req_data, fifo_full, fifo_almostfull, fifo_wr_ack,
               fifo_overflow, clr_err,
        output req_ready, fifo_wr_en, fifo_data_in, grant_id, wr_count, err_overflow
    );
    modport slave (
        output req_valid, req_data, fifo_full, fifo_almostfull, fifo_wr_ack,
               fifo_overflow, clr_err,
        input  req_ready, fifo_wr_en, fifo_data_in, grant_id, wr_count, err_overflow
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter with bounded burst lock sharing one FIFO write port.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fifo_wr_arbiter_if.master
//           requesters -> req_valid/req_data in, req_ready out (combinational, one-hot or zero)
//           FIFO       -> registered fifo_wr_en/fifo_data_in out; full/almostfull/wr_ack/overflow in
//           status     -> grant_id, wr_count, sticky err_overflow (cleared by clr_err)
module fifo_wr_arbiter #(
    parameter int N         = 4,
    parameter int W         = 16,
    parameter int MAX_BURST = 4
) (
    input logic               clk,
    input logic               rst_n,
    fifo_wr_arbiter_if.master bus
);
    localparam int IW = $clog2(N);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d, grant_q, grant_d;
    logic [3:0]    burst_q, burst_d;
    logic          wr_en_q, wr_en_d;
    logic [W-1:0]  data_q, data_d, picked;
    logic [15:0]   wr_count_q;
    logic          err_q;
    logic [IW-1:0] win, idx, sel;
    logic [N-1:0]  ready;
    logic          any, go, space_ok;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (int'(i) == N - 1) ? '0 : i + 1'b1;
    endfunction

    // The in-flight write (wr_en_q) may take the last free slot, so almostfull already blocks.
    assign space_ok = !bus.fifo_full && !(bus.fifo_almostfull && wr_en_q);

    // Highest k is visited first so the lowest rotated distance from rr_ptr wins.
    always_comb begin
        win = '0;
        idx = '0;
        any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IW'((int'(rr_ptr_q) + k) % N);
            if (bus.req_valid[idx]) begin
                win = idx;
                any = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        burst_d  = burst_q;
        grant_d  = grant_q;
        ready    = '0;
        go       = 1'b0;
        sel      = grant_q;
        if (state_q == IDLE) begin
            if (space_ok && any) begin
                ready[win] = 1'b1;
                go         = 1'b1;
                sel        = win;
                burst_d    = 4'd1;
                grant_d    = win;
                if (MAX_BURST > 1) state_d = BURST;
                else rr_ptr_d = next_idx(win);
            end
        end else begin
            if (!bus.req_valid[grant_q]) begin
                // owner went away: spend one bubble and re-arbitrate from the next index
                rr_ptr_d = next_idx(grant_q);
                state_d  = IDLE;
            end else if (space_ok && burst_q < 4'(MAX_BURST)) begin
                ready[grant_q] = 1'b1;
                go             = 1'b1;
                burst_d        = burst_q + 4'd1;
                if (burst_q + 4'd1 == 4'(MAX_BURST)) begin
                    rr_ptr_d = next_idx(grant_q);
                    state_d  = IDLE;
                end
            end
        end
    end

    always_comb begin
        picked = '0;
        for (int i = 0; i < N; i++) picked = (sel == IW'(i)) ? bus.req_data[i*W +: W] : picked;
    end

    assign wr_en_d = go;
    assign data_d  = go ? picked : data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            burst_q    <= '0;
            grant_q    <= '0;
            wr_en_q    <= 1'b0;
            data_q     <= '0;
            wr_count_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            burst_q    <= burst_d;
            grant_q    <= grant_d;
            wr_en_q    <= wr_en_d;
            data_q     <= data_d;
            wr_count_q <= wr_count_q + 16'(bus.fifo_wr_ack);
            err_q      <= bus.fifo_overflow | (err_q & ~bus.clr_err);
        end
    end

    assign bus.req_ready    = rst_n ? ready : '0;
    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_data_in = data_q;
    assign bus.grant_id     = grant_q;
    assign bus.wr_count     = wr_count_q;
    assign bus.err_overflow = err_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios for fifo_wr_arbiter against a small 8-deep FIFO model.
module tb_fifo_wr_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic drain = 1'b1;
    logic force_ovf = 1'b0;
    logic [3:0] fcount;
    logic ack_q, ovf_q;
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N(4), .W(16)) bus ();

    fifo_wr_arbiter #(.N(4), .W(16), .MAX_BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 8-deep FIFO occupancy model; optional read every cycle when drain=1
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcount <= '0;
            ack_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            ack_q  <= bus.fifo_wr_en && fcount != 4'd8;
            ovf_q  <= bus.fifo_wr_en && fcount == 4'd8;
            fcount <= fcount + 4'(bus.fifo_wr_en && fcount != 4'd8) - 4'(drain && fcount != 4'd0);
        end
    end

    assign bus.fifo_full       = fcount == 4'd8;
    assign bus.fifo_almostfull = fcount == 4'd7;
    assign bus.fifo_wr_ack     = ack_q;
    assign bus.fifo_overflow   = ovf_q | force_ovf;

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.clr_err = 1'b0;
        force_ovf = 1'b0;
        drain = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.clr_err = 1'b0;
        bus.req_data = '0;
        bus.req_valid = 4'b1111;
        @(negedge clk);
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
        checks++; if (bus.fifo_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %b want 0", bus.fifo_wr_en); end
        checks++; if (bus.grant_id !== 2'd0) begin fails++; $display("FAIL reset_grant: got %0d want 0", bus.grant_id); end
        checks++; if (bus.fifo_data_in !== 16'h0) begin fails++; $display("FAIL reset_data: got %h want 0000", bus.fifo_data_in); end
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #1;
            checks++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL idle_ready: got %b want 0000", bus.req_ready); end
            checks++; if (bus.fifo_wr_en !== 1'b0) begin fails++; $display("FAIL idle_wr_en: got %b want 0", bus.fifo_wr_en); end
        end
        checks++; if (bus.wr_count !== 16'd0) begin fails++; $display("FAIL idle_wr_count: got %0d want 0", bus.wr_count); end
        checks++; if (bus.err_overflow !== 1'b0) begin fails++; $display("FAIL idle_err: got %b want 0", bus.err_overflow); end
    endtask

    task automatic test_single_stream();
        int sent = 0;
        logic exp_en = 1'b0;
        logic [15:0] exp_d = 16'h0;
        logic [3:0] exp_rdy;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            bus.req_valid = (sent < 6) ? 4'b0100 : 4'b0000;
            bus.req_data = '0;
            bus.req_data[32 +: 16] = 16'hA000 + 16'(sent);
            #1;
            exp_rdy = (sent < 6) ? 4'b0100 : 4'b0000;
            checks++; if (bus.req_ready !== exp_rdy) begin fails++; $display("FAIL stream_ready c%0d: got %b want %b", c, bus.req_ready, exp_rdy); end
            checks++; if (bus.fifo_wr_en !== exp_en) begin fails++; $display("FAIL stream_wr_en c%0d: got %b want %b", c, bus.fifo_wr_en, exp_en); end
            checks++; if (bus.fifo_data_in !== exp_d) begin fails++; $display("FAIL stream_data c%0d: got %h want %h", c, bus.fifo_data_in, exp_d); end
            if (exp_rdy != 4'b0000) begin
                exp_en = 1'b1;
                exp_d = 16'hA000 + 16'(sent);
                sent++;
            end else begin
                exp_en = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.wr_count !== 16'd6) begin fails++; $display("FAIL stream_wr_count: got %0d want 6", bus.wr_count); end
        checks++; if (bus.grant_id !== 2'd2) begin fails++; $display("FAIL stream_grant: got %0d want 2", bus.grant_id); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            bus.req_valid = 4'b1111;
            bus.req_data = {16'hD000, 16'hC000, 16'hB000, 16'hA000} + 64'(i);
            #1;
            exp_rdy = 4'(1 << ((i / 4) % 4));
            checks++; if (bus.req_ready !== exp_rdy) begin fails++; $display("FAIL rr_ready i%0d: got %b want %b", i, bus.req_ready, exp_rdy); end
        end
    endtask

    task automatic test_fill_no_read();
        logic [3:0] exp_rdy;
        do_reset();
        drain = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.req_valid = 4'b0011;
            bus.req_data = 64'h3333_2222_1111_0000 + 64'(i);
            #1;
            exp_rdy = (i < 4) ? 4'b0001 : (i < 8) ? 4'b0010 : 4'b0000;
            checks++; if (bus.req_ready !== exp_rdy) begin fails++; $display("FAIL fill_ready i%0d: got %b want %b", i, bus.req_ready, exp_rdy); end
            checks++; if (bus.fifo_overflow !== 1'b0) begin fails++; $display("FAIL fill_overflow i%0d: got %b want 0", i, bus.fifo_overflow); end
        end
        checks++; if (fcount !== 4'd8) begin fails++; $display("FAIL fill_writes: got %0d want 8", fcount); end
        checks++; if (bus.wr_count !== 16'd8) begin fails++; $display("FAIL fill_wr_count: got %0d want 8", bus.wr_count); end
        checks++; if (bus.fifo_wr_en !== 1'b0) begin fails++; $display("FAIL fill_wr_en: got %b want 0", bus.fifo_wr_en); end
        checks++; if (bus.err_overflow !== 1'b0) begin fails++; $display("FAIL fill_err: got %b want 0", bus.err_overflow); end
        drain = 1'b1;
    endtask

    task automatic test_owner_drop();
        do_reset();
        @(negedge clk);
        bus.req_valid = 4'b1010;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin fails++; $display("FAIL drop_c0_ready: got %b want 0010", bus.req_ready); end
        @(negedge clk);
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin fails++; $display("FAIL drop_c1_ready: got %b want 0010", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 4'b1001;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL drop_bubble_ready: got %b want 0000", bus.req_ready); end
        checks++; if (bus.fifo_wr_en !== 1'b1) begin fails++; $display("FAIL drop_c2_wr_en: got %b want 1", bus.fifo_wr_en); end
        @(negedge clk);
        #1;
        checks++; if (bus.req_ready !== 4'b1000) begin fails++; $display("FAIL drop_regrant_ready: got %b want 1000", bus.req_ready); end
        checks++; if (bus.fifo_wr_en !== 1'b0) begin fails++; $display("FAIL drop_bubble_wr_en: got %b want 0", bus.fifo_wr_en); end
        checks++; if (bus.grant_id !== 2'd1) begin fails++; $display("FAIL drop_c3_grant: got %0d want 1", bus.grant_id); end
        @(negedge clk);
        bus.req_valid = 4'b0000;
        #1;
        checks++; if (bus.grant_id !== 2'd3) begin fails++; $display("FAIL drop_c4_grant: got %0d want 3", bus.grant_id); end
        checks++; if (bus.fifo_wr_en !== 1'b1) begin fails++; $display("FAIL drop_c4_wr_en: got %b want 1", bus.fifo_wr_en); end
    endtask

    task automatic test_reset_mid_burst();
        logic [3:0] exp_rdy;
        do_reset();
        repeat (6) begin
            @(negedge clk);
            bus.req_valid = 4'b0100;
            bus.req_data = 64'h0000_5A5A_0000_0000;
        end
        @(negedge clk);
        #1;
        checks++; if (bus.fifo_wr_en !== 1'b1) begin fails++; $display("FAIL mid_pre_wr_en: got %b want 1", bus.fifo_wr_en); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.fifo_wr_en !== 1'b0) begin fails++; $display("FAIL mid_rst_wr_en: got %b want 0", bus.fifo_wr_en); end
        checks++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL mid_rst_ready: got %b want 0000", bus.req_ready); end
        checks++; if (bus.grant_id !== 2'd0) begin fails++; $display("FAIL mid_rst_grant: got %0d want 0", bus.grant_id); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            bus.req_valid = 4'b1101;
            #1;
            exp_rdy = (i < 4) ? 4'b0001 : 4'b0100;
            checks++; if (bus.req_ready !== exp_rdy) begin fails++; $display("FAIL mid_post_ready i%0d: got %b want %b", i, bus.req_ready, exp_rdy); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        @(negedge clk);
        #1;
        checks++; if (bus.err_overflow !== 1'b0) begin fails++; $display("FAIL ovf_initial: got %b want 0", bus.err_overflow); end
        force_ovf = 1'b1;
        bus.clr_err = 1'b1;
        @(negedge clk);
        force_ovf = 1'b0;
        bus.clr_err = 1'b0;
        #1;
        checks++; if (bus.err_overflow !== 1'b1) begin fails++; $display("FAIL ovf_set_wins: got %b want 1", bus.err_overflow); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.err_overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", bus.err_overflow); end
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        #1;
        checks++; if (bus.err_overflow !== 1'b0) begin fails++; $display("FAIL ovf_cleared: got %b want 0", bus.err_overflow); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_stream();
        test_round_robin();
        test_fill_no_read();
        test_owner_drop();
        test_reset_mid_burst();
        test_overflow();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
